// File: rtl/fp_pkg.sv
// fp_pkg
//   Shared floating-point definitions for the fp datapath (fadd, ftoi).
//   Holds the default single-precision field geometry, the packed field
//   struct, the operand class enum and the exponent-bias helper.
//   No ports; imported with "import fp_pkg::*;".
package fp_pkg;

  localparam int FP_N = 32;
  localparam int FP_E = 8;
  localparam int FP_S = 1;
  localparam int FP_M = FP_N - FP_E - FP_S;

  typedef struct packed {
    logic            sign;
    logic [FP_E-1:0] exp;
    logic [FP_M-1:0] mant;
  } fp_fields_t;

  typedef enum logic [1:0] {
    ZERO,
    NORMAL,
    INF,
    NAN
  } fp_class_e;

  // Exponent bias for an e-bit exponent field: 2^(e-1)-1.
  function automatic int fp_bias(input int e);
    return (1 << (e - 1)) - 1;
  endfunction

endpackage

// File: rtl/fp_unpack.sv
// fp_unpack
//   Combinational split of a packed float into the pieces the arithmetic
//   stages want: sign, significand with the hidden one restored, unbiased
//   exponent and operand class.
//   Ports:
//     op        in   N      packed float {sign, exp, mant}
//     sign      out  1      sign bit
//     uexp      out  E+1    exponent minus bias, signed
//     sig       out  M+1    {1, mant}
//     mant_zero out  1      mantissa field is all zeros
//     cls       out  class  ZERO / NORMAL / INF / NAN
module fp_unpack
  import fp_pkg::*;
#(
  parameter int N = FP_N,
  parameter int E = FP_E,
  parameter int S = FP_S
) (
  input  logic [N-1:0]       op,
  output logic               sign,
  output logic signed [E:0]  uexp,
  output logic [N-E-S:0]     sig,
  output logic               mant_zero,
  output fp_class_e          cls
);

  localparam int M = N - E - S;
  localparam logic [E:0] BIAS = (E+1)'(fp_bias(E));

  logic [E-1:0] exp_f;
  logic [M-1:0] mant_f;

  assign sign      = op[N-1];
  assign exp_f     = op[N-2 -: E];
  assign mant_f    = op[M-1:0];
  assign mant_zero = (mant_f == '0);

  // The hidden one is inserted unconditionally; denormals never use the
  // significand because they are classified as ZERO.
  assign sig  = {1'b1, mant_f};
  assign uexp = $signed({1'b0, exp_f} - BIAS);

  // Class decode from the exponent field, with the mantissa separating
  // infinity from NaN.
  always_comb begin
    cls = NORMAL;
    if (exp_f == '0) begin
      cls = ZERO;
    end else if (exp_f == '1) begin
      cls = mant_zero ? INF : NAN;
    end
  end

endmodule

// File: rtl/ftoi.sv
// ftoi
//   Three-stage pipelined float-to-signed-integer converter. Truncates
//   toward zero and saturates on overflow, Inf and NaN. One operand per
//   cycle, no backpressure, results emerge three cycles after acceptance.
//   Ports:
//     clk      in   1  clock, rising edge
//     rst      in   1  synchronous active-high reset
//     en       in   1  operand valid
//     op       in   N  packed float {sign, exp, mant}
//     res_val  out  1  result valid
//     res      out  N  two's-complement result, 0 when res_val is low
//     res_ovf  out  1  result saturated, 0 when res_val is low
module ftoi
  import fp_pkg::*;
#(
  parameter int N = FP_N,
  parameter int E = FP_E,
  parameter int S = FP_S
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [N-1:0] op,
  output logic         res_val,
  output logic [N-1:0] res,
  output logic         res_ovf
);

  localparam int M = N - E - S;

  localparam logic [N-1:0] INT_MAX = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0] INT_MIN = {1'b1, {(N-1){1'b0}}};

  // Exponent landmarks: above N-2 the magnitude no longer fits a positive
  // integer; N-1 is only representable as exactly -2^(N-1).
  localparam logic signed [E:0] U_TOP  = (E+1)'(N - 2);
  localparam logic signed [E:0] U_EDGE = (E+1)'(N - 1);
  localparam logic signed [E:0] U_M    = (E+1)'(M);

  // Unpacked view of the incoming operand
  logic               up_sign;
  logic signed [E:0]  up_uexp;
  logic [M:0]         up_sig;
  logic               up_mzero;
  fp_class_e          up_cls;

  fp_unpack #(.N(N), .E(E), .S(S)) u_unpack (
    .op        (op),
    .sign      (up_sign),
    .uexp      (up_uexp),
    .sig       (up_sig),
    .mant_zero (up_mzero),
    .cls       (up_cls)
  );

  // Stage 0 registers
  logic               v1;
  logic               s0_sign;
  logic signed [E:0]  s0_u;
  logic [M:0]         s0_sig;
  logic               s0_mzero;
  fp_class_e          s0_cls;

  // Stage 1 registers
  logic               v2;
  logic               s1_sign;
  logic [N-1:0]       s1_mag;
  logic               s1_sat;
  logic [N-1:0]       s1_sat_val;
  logic               s1_ovf;

  // Stage 1 combinational results
  logic [N-1:0]       mag_d;
  logic               sat_d;
  logic [N-1:0]       sat_val_d;
  logic               ovf_d;
  logic [N-1:0]       sig_ext;
  logic [E:0]         shl_amt;
  logic [E:0]         shr_amt;

  // Valid pipe. Only the valids carry reset, so an in-flight operand is
  // dropped simply by losing its valid bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
    end else begin
      v1 <= en;
      v2 <= v1;
    end
  end

  // Data registers capture every cycle; their contents only matter when
  // the matching valid is set.
  always_ff @(posedge clk) begin
    s0_sign    <= up_sign;
    s0_u       <= up_uexp;
    s0_sig     <= up_sig;
    s0_mzero   <= up_mzero;
    s0_cls     <= up_cls;
    s1_sign    <= s0_sign;
    s1_mag     <= mag_d;
    s1_sat     <= sat_d;
    s1_sat_val <= sat_val_d;
    s1_ovf     <= ovf_d;
  end

  // Alignment shift and saturation pre-selection. Shift amounts are only
  // meaningful in the in-range NORMAL branch, where 0 <= u <= N-2.
  always_comb begin
    mag_d     = '0;
    sat_d     = 1'b0;
    sat_val_d = '0;
    ovf_d     = 1'b0;
    sig_ext   = {{(N-M-1){1'b0}}, s0_sig};
    shl_amt   = s0_u - U_M;
    shr_amt   = U_M - s0_u;
    unique case (s0_cls)
      ZERO: begin
        mag_d = '0;
      end
      INF: begin
        sat_d     = 1'b1;
        ovf_d     = 1'b1;
        sat_val_d = s0_sign ? INT_MIN : INT_MAX;
      end
      NAN: begin
        sat_d     = 1'b1;
        ovf_d     = 1'b1;
        sat_val_d = INT_MAX;
      end
      NORMAL: begin
        if (s0_u < 0) begin
          mag_d = '0;
        end else if (s0_u > U_TOP) begin
          sat_d = 1'b1;
          if (s0_sign && (s0_u == U_EDGE) && s0_mzero) begin
            sat_val_d = INT_MIN;
          end else begin
            ovf_d     = 1'b1;
            sat_val_d = s0_sign ? INT_MIN : INT_MAX;
          end
        end else if (s0_u >= U_M) begin
          mag_d = sig_ext << shl_amt;
        end else begin
          mag_d = sig_ext >> shr_amt;
        end
      end
      default: begin
        mag_d = '0;
      end
    endcase
  end

  // Output stage: negate, pick saturation, and force zeros on idle cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_val <= 1'b0;
      res     <= '0;
      res_ovf <= 1'b0;
    end else begin
      res_val <= v2;
      if (v2) begin
        res     <= s1_sat ? s1_sat_val : (s1_sign ? -s1_mag : s1_mag);
        res_ovf <= s1_ovf;
      end else begin
        res     <= '0;
        res_ovf <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ftoi.sv
// tb_ftoi
//   Directed and random-stream bench for ftoi. Inputs are driven on the
//   falling edge; outputs are sampled on the falling edge before new
//   inputs are applied. An operand driven at falling edge k is seen on
//   the outputs at falling edge k+3.
module tb_ftoi;

  logic        clk;
  logic        rst;
  logic        en;
  logic [31:0] op;
  logic        res_val;
  logic [31:0] res;
  logic        res_ovf;

  int checks   = 0;
  int failures = 0;

  // Stimulus slots and the outputs captured for each slot
  logic [31:0] vec_op  [8];
  logic        vec_en  [8];
  logic        obs_val [8];
  logic [31:0] obs_res [8];
  logic        obs_ovf [8];

  typedef struct packed {
    logic        v;
    logic [31:0] r;
    logic        o;
  } exp_t;

  ftoi dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .op      (op),
    .res_val (res_val),
    .res     (res),
    .res_ovf (res_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference conversion in real arithmetic: returns {ovf, result}
  function automatic logic [32:0] ref_ftoi(input logic [31:0] f);
    real mag_r;
    real val_r;
    int  e;
    e = int'(f[30:23]);
    if (e == 255) begin
      if (f[22:0] != 23'd0) return {1'b1, 32'h7FFFFFFF};
      return f[31] ? {1'b1, 32'h80000000} : {1'b1, 32'h7FFFFFFF};
    end
    if (e == 0) return {1'b0, 32'd0};
    mag_r = (1.0 + real'(f[22:0]) / 8388608.0) * (2.0 ** real'(e - 127));
    val_r = f[31] ? -mag_r : mag_r;
    if (val_r >= 2147483648.0) return {1'b1, 32'h7FFFFFFF};
    if (val_r < -2147483648.0) return {1'b1, 32'h80000000};
    return {1'b0, 32'($rtoi(val_r))};
  endfunction

  // Drive n slots back-to-back and capture each slot's output three
  // cycles later. Leaves en low afterwards.
  task automatic run_vectors(input int n);
    for (int c = 0; c < n + 3; c++) begin
      @(negedge clk);
      if (c >= 3) begin
        obs_val[c-3] = res_val;
        obs_res[c-3] = res;
        obs_ovf[c-3] = res_ovf;
      end
      if (c < n) begin
        en = vec_en[c];
        op = vec_op[c];
      end else begin
        en = 1'b0;
        op = 32'd0;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    en  = 1'b1;
    op  = 32'h3F800000;
    repeat (3) @(negedge clk);
    checks++;
    if (res_val !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset res_val: got %b expected 0", res_val);
    end
    checks++;
    if (res !== 32'd0) begin
      failures++;
      $display("[TB] FAIL reset res: got %h expected 00000000", res);
    end
    checks++;
    if (res_ovf !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset res_ovf: got %b expected 0", res_ovf);
    end
    rst = 1'b0;
    en  = 1'b0;
    op  = 32'd0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if (res_val !== 1'b0 || res !== 32'd0 || res_ovf !== 1'b0) begin
        failures++;
        $display("[TB] FAIL reset_ignored_en[%0d]: got val=%b res=%h ovf=%b expected 0/00000000/0",
                 c, res_val, res, res_ovf);
      end
    end
  endtask

  task automatic test_basic();
    logic [31:0] er [5];
    logic        ev [5];
    vec_op[0] = 32'h3F800000; er[0] = 32'h00000001; ev[0] = 1'b1;
    vec_op[1] = 32'hC0200000; er[1] = 32'hFFFFFFFE; ev[1] = 1'b1;
    vec_op[2] = 32'h47F12000; er[2] = 32'h0001E240; ev[2] = 1'b1;
    vec_op[3] = 32'h3F800000; er[3] = 32'h00000000; ev[3] = 1'b0;
    vec_op[4] = 32'h3F800000; er[4] = 32'h00000000; ev[4] = 1'b0;
    for (int i = 0; i < 5; i++) vec_en[i] = (i < 3);
    run_vectors(5);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (obs_val[i] !== ev[i]) begin
        failures++;
        $display("[TB] FAIL basic val[%0d]: got %b expected %b", i, obs_val[i], ev[i]);
      end
      checks++;
      if (obs_res[i] !== er[i]) begin
        failures++;
        $display("[TB] FAIL basic res[%0d]: got %h expected %h", i, obs_res[i], er[i]);
      end
      checks++;
      if (obs_ovf[i] !== 1'b0) begin
        failures++;
        $display("[TB] FAIL basic ovf[%0d]: got %b expected 0", i, obs_ovf[i]);
      end
    end
  endtask

  task automatic test_small();
    vec_op[0] = 32'h3F400000;
    vec_op[1] = 32'hBF400000;
    vec_op[2] = 32'h80000000;
    vec_op[3] = 32'h00000001;
    for (int i = 0; i < 4; i++) vec_en[i] = 1'b1;
    run_vectors(4);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (obs_val[i] !== 1'b1) begin
        failures++;
        $display("[TB] FAIL small val[%0d]: got %b expected 1", i, obs_val[i]);
      end
      checks++;
      if (obs_res[i] !== 32'd0) begin
        failures++;
        $display("[TB] FAIL small res[%0d]: got %h expected 00000000", i, obs_res[i]);
      end
      checks++;
      if (obs_ovf[i] !== 1'b0) begin
        failures++;
        $display("[TB] FAIL small ovf[%0d]: got %b expected 0", i, obs_ovf[i]);
      end
    end
  endtask

  task automatic test_boundaries();
    logic [31:0] er [4];
    logic        eo [4];
    vec_op[0] = 32'h4EFFFFFF; er[0] = 32'h7FFFFF80; eo[0] = 1'b0;
    vec_op[1] = 32'h4F000000; er[1] = 32'h7FFFFFFF; eo[1] = 1'b1;
    vec_op[2] = 32'hCF000000; er[2] = 32'h80000000; eo[2] = 1'b0;
    vec_op[3] = 32'hCF000001; er[3] = 32'h80000000; eo[3] = 1'b1;
    for (int i = 0; i < 4; i++) vec_en[i] = 1'b1;
    run_vectors(4);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (obs_val[i] !== 1'b1) begin
        failures++;
        $display("[TB] FAIL boundary val[%0d]: got %b expected 1", i, obs_val[i]);
      end
      checks++;
      if (obs_res[i] !== er[i]) begin
        failures++;
        $display("[TB] FAIL boundary res[%0d]: got %h expected %h", i, obs_res[i], er[i]);
      end
      checks++;
      if (obs_ovf[i] !== eo[i]) begin
        failures++;
        $display("[TB] FAIL boundary ovf[%0d]: got %b expected %b", i, obs_ovf[i], eo[i]);
      end
    end
  endtask

  task automatic test_specials();
    logic [31:0] er [4];
    vec_op[0] = 32'h7F800000; er[0] = 32'h7FFFFFFF;
    vec_op[1] = 32'hFF800000; er[1] = 32'h80000000;
    vec_op[2] = 32'h7FC00000; er[2] = 32'h7FFFFFFF;
    vec_op[3] = 32'hFFC00000; er[3] = 32'h7FFFFFFF;
    for (int i = 0; i < 4; i++) vec_en[i] = 1'b1;
    run_vectors(4);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (obs_val[i] !== 1'b1) begin
        failures++;
        $display("[TB] FAIL special val[%0d]: got %b expected 1", i, obs_val[i]);
      end
      checks++;
      if (obs_res[i] !== er[i]) begin
        failures++;
        $display("[TB] FAIL special res[%0d]: got %h expected %h", i, obs_res[i], er[i]);
      end
      checks++;
      if (obs_ovf[i] !== 1'b1) begin
        failures++;
        $display("[TB] FAIL special ovf[%0d]: got %b expected 1", i, obs_ovf[i]);
      end
    end
  endtask

  // Three operands in flight, reset with the third; nothing may emerge.
  // A fresh operand two cycles after reset comes out normally.
  task automatic test_reset_midflight();
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      if (c >= 3 && c <= 6) begin
        checks++;
        if (res_val !== 1'b0 || res !== 32'd0 || res_ovf !== 1'b0) begin
          failures++;
          $display("[TB] FAIL midflight_drop[t+%0d]: got val=%b res=%h ovf=%b expected 0/00000000/0",
                   c, res_val, res, res_ovf);
        end
      end
      if (c == 7) begin
        checks++;
        if (res_val !== 1'b1 || res !== 32'h00000003 || res_ovf !== 1'b0) begin
          failures++;
          $display("[TB] FAIL midflight_new: got val=%b res=%h ovf=%b expected 1/00000003/0",
                   res_val, res, res_ovf);
        end
      end
      if (c == 8) begin
        checks++;
        if (res_val !== 1'b0 || res !== 32'd0) begin
          failures++;
          $display("[TB] FAIL midflight_idle: got val=%b res=%h expected 0/00000000",
                   res_val, res);
        end
      end
      rst = 1'b0;
      en  = 1'b0;
      op  = 32'd0;
      case (c)
        0: begin en = 1'b1; op = 32'h3F800000; end
        1: begin en = 1'b1; op = 32'hC0200000; end
        2: begin en = 1'b1; op = 32'h47F12000; rst = 1'b1; end
        4: begin en = 1'b1; op = 32'h40400000; end
        default: ;
      endcase
    end
  endtask

  task automatic test_random_stream();
    exp_t        q[$];
    exp_t        e;
    logic [32:0] m;
    logic [31:0] o;
    logic        go;
    for (int c = 0; c < 10003; c++) begin
      @(negedge clk);
      if (q.size() == 3) begin
        e = q.pop_front();
        checks++;
        if (res_val !== e.v) begin
          failures++;
          $display("[TB] FAIL random val[%0d]: got %b expected %b", c, res_val, e.v);
        end
        checks++;
        if (res !== e.r) begin
          failures++;
          $display("[TB] FAIL random res[%0d]: got %h expected %h", c, res, e.r);
        end
        checks++;
        if (res_ovf !== e.o) begin
          failures++;
          $display("[TB] FAIL random ovf[%0d]: got %b expected %b", c, res_ovf, e.o);
        end
      end
      o  = 32'd0;
      go = 1'b0;
      if (c < 10000) begin
        go = 1'($urandom_range(1, 0));
        case ($urandom_range(3, 0))
          0: o = $urandom;
          1, 2: o = {1'($urandom), 8'($urandom_range(160, 100)), 23'($urandom)};
          default: o = {1'($urandom), 8'($urandom_range(158, 156)), 23'($urandom_range(3, 0))};
        endcase
      end
      en = go;
      op = o;
      if (go) begin
        m = ref_ftoi(o);
        q.push_back({1'b1, m[31:0], m[32]});
      end else begin
        q.push_back({1'b0, 32'd0, 1'b0});
      end
    end
    en = 1'b0;
    op = 32'd0;
  endtask

  initial begin
    rst = 1'b1;
    en  = 1'b0;
    op  = 32'd0;
    test_reset();
    test_basic();
    test_small();
    test_boundaries();
    test_specials();
    test_reset_midflight();
    test_random_stream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
